dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Responder end of the MEM-stage data-memory interface. The pipeline's MEM stage is the initiator: it drives mem_read/mem_write, adr and write_data.
- This block holds a word-addressed storage array and inserts LATENCY wait states on every access.
- It raises stall to freeze the pipeline latches until the access completes, then returns read data and a one-cycle ready.
- It also exposes two fixed debug words, out1 and out2.

Parameters:
- DEPTH, 256, number of 32-bit words (power of 2).
- LATENCY, 1, extra wait cycles per access (0..15).
- OUT1_IDX, 0, word index driven on out1.
- OUT2_IDX, 1, word index driven on out2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  read request, level; held by the initiator while stall=1.
- mem_write  in  1  write request, level; held while stall=1.
- adr  in  32  byte address.
- write_data  in  32  store data.
- read_data  out  32  load result, registered.
- ready  out  1  access complete this cycle.
- stall  out  1  freeze request to the fetch/decode/exe/mem latches.
- misaligned  out  1  sticky flag: an access was made with adr[1:0]!=0.
- out1  out  32  mem[OUT1_IDX], combinational.
- out2  out  32  mem[OUT2_IDX], combinational.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0.
  - read_data=0, ready=0, stall=0, misaligned=0.
  - All memory words=0, so out1=out2=0.
- Indexing:
  - idx = adr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias (wrap) modulo DEPTH words.
  - adr[1:0] is ignored for indexing. Any access with adr[1:0]!=0 sets misaligned until the next reset.
- req = mem_read | mem_write.
- If mem_read and mem_write are both 1, the access is a write; read_data is not updated.
- FSM states are IDLE, WAIT and DONE:
  - IDLE:
    - ready=0; stall=req (combinational, same cycle the request appears).
    - If req and LATENCY==0: perform the access on this edge and go to DONE.
    - If req and LATENCY>0: cnt<=LATENCY-1 and go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - stall=1, ready=0.
    - If cnt==0: perform the access on this edge and go to DONE. Otherwise cnt<=cnt-1.
    - Request inputs are sampled only on the access edge. The initiator is frozen, so they are stable.
    - If req drops in WAIT (protocol violation), the access still completes using the inputs sampled on the access edge.
  - DONE:
    - stall=0, ready=1.
    - read_data holds the loaded word: captured as mem[idx] for a read; unchanged for a write.
    - The pipeline advances on this edge. Next state is IDLE unconditionally, so the request still present in DONE is never re-issued.
- Timing:
  - stall is high for exactly LATENCY+1 cycles per access.
  - Access-to-ready latency is LATENCY+1 cycles after the request first appears.
  - A back-to-back request reaches IDLE one cycle after DONE.
- Writes update mem[idx] on the access edge. out1/out2 reflect the new value from the next cycle onward.
- read_data holds its value between accesses. It changes only on a read's access edge or on reset.
- Reset asserted mid-access: the FSM returns to IDLE immediately, stall drops asynchronously, and the pending write is discarded.
- After rst deasserts, a still-held request starts a fresh access.

Decomposition:
- Shared package holds:
  - state encoding, IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - WORD_BYTES=4.
- One natural sub-module, dmem_array: the DEPTH x 32 storage with async clear, write port and read port, and the two fixed debug taps.
- The FSM, counter and misaligned flag stay in dmem_responder.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> read_data=0, stall=0, ready=0, out1=out2=0, with no clock edge needed.
- Write then read, LATENCY=1:
  - mem_write with adr=0x4, write_data=0xDEADBEEF -> stall=1 for 2 cycles, ready=1 in cycle 3, out2=0xDEADBEEF afterwards.
  - mem_read with adr=0x4 -> read_data=0xDEADBEEF on its ready cycle.
- LATENCY=0 and LATENCY=3:
  - read of adr=0x8 -> stall width 1 and 4 cycles respectively, with ready exactly one cycle after stall falls.
  - Back-to-back requests each get their own stall window.
- Alias, misaligned and dual request (DEPTH=256):
  - write 0x12345678 to adr=0x400 -> mem[0] updates, so out1=0x12345678.
  - read adr=0x402 -> misaligned=1 and stays set.
  - mem_read and mem_write together -> write performed, read_data unchanged.
- Reset mid-WAIT (LATENCY=3): write 0xAAAA5555 to adr=0x0, assert rst in the second stall cycle -> stall=0 immediately, out1 stays 0.
- Dropped request (LATENCY=2): deassert req in WAIT -> FSM still reaches DONE, with ready=1 for one cycle only.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t    : responder FSM encoding (IDLE, WAIT, DONE)
//   DATA_W     : width of one memory word
//   WORD_BYTES : bytes per word, sets which address bits are the byte offset
//   is_misaligned() : true when a byte address is not word aligned
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int OFS_W      = $clog2(WORD_BYTES);

  function automatic logic is_misaligned(input logic [DATA_W-1:0] a);
    return a[OFS_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus.
//   master : the pipeline MEM stage (drives requests, receives data/handshake)
//   slave  : the memory responder
// Signals: mem_read, mem_write (level requests), adr (byte address),
//          write_data, read_data, ready (access done), stall (freeze pipeline).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] adr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;
  logic              stall;

  modport master (
    output mem_read, mem_write, adr, write_data,
    input  read_data, ready, stall
  );

  modport slave (
    input  mem_read, mem_write, adr, write_data,
    output read_data, ready, stall
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage for the data-memory responder.
// Ports:
//   clk, rst          : clock, asynchronous active-high clear of every word
//   wr_en/idx/wr_data : synchronous write port
//   rd_word           : combinational read of word idx
//   out1, out2        : combinational taps on words OUT1_IDX and OUT2_IDX
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int OUT1_IDX = 0,
  parameter int OUT2_IDX = 1,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2
);

  localparam logic [IDX_W-1:0] TAP1 = IDX_W'(OUT1_IDX);
  localparam logic [IDX_W-1:0] TAP2 = IDX_W'(OUT2_IDX);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_word = mem[idx];
  assign out1    = mem[TAP1];
  assign out2    = mem[TAP2];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface.
// Every access waits LATENCY extra cycles: stall freezes the pipeline from the
// cycle the request appears until the access edge, then ready pulses for one
// cycle with read_data holding the loaded word.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : slave side of dmem_responder_if
//   misaligned : sticky, set by any access whose adr[1:0] != 0
//   out1, out2 : debug taps on words OUT1_IDX / OUT2_IDX
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 1,
  parameter int OUT1_IDX = 0,
  parameter int OUT2_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              misaligned,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              req;
  logic              access;
  logic              wr_en;
  logic              rd_en;
  logic              stall_c;
  logic              ready_c;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] read_data_q;
  logic              adr_unused;

  // Upper address bits alias onto the array.
  assign idx        = bus.adr[IDX_W+1:2];
  assign adr_unused = ^bus.adr[DATA_W-1:IDX_W+2];
  assign req        = bus.mem_read | bus.mem_write;

  // A simultaneous read+write is treated as a write only.
  assign wr_en = access & bus.mem_write;
  assign rd_en = access & bus.mem_read & ~bus.mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    stall_c   = 1'b0;
    ready_c   = 1'b0;
    case (state)
      IDLE: begin
        // Stall must rise in the same cycle the request appears; rst gating
        // keeps it low while reset is held against a pending request.
        stall_c = req & ~rst;
        if (req) begin
          if (LATENCY == 0) begin
            access    = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        // The request is still visible here; returning to IDLE without
        // looking at it prevents the finished access from being re-issued.
        ready_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= '0;
      misaligned  <= 1'b0;
    end else begin
      if (rd_en) read_data_q <= rd_word;
      if (access && is_misaligned(bus.adr)) misaligned <= 1'b1;
    end
  end

  dmem_array #(
    .DEPTH    (DEPTH),
    .OUT1_IDX (OUT1_IDX),
    .OUT2_IDX (OUT2_IDX)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .idx     (idx),
    .wr_data (bus.write_data),
    .rd_word (rd_word),
    .out1    (out1),
    .out2    (out2)
  );

  assign bus.read_data = read_data_q;
  assign bus.stall     = stall_c;
  assign bus.ready     = ready_c;

endmodule
